// File: rtl/pc_sequencer_if.sv
// Fetch and decode-side signal bundle for pc_sequencer.
// The master modport is the sequencer; the slave modport is memory plus decode/control.
interface pc_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        decode_ready;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        branch;
    logic        jump;
    logic        jal;
    logic        jr;
    logic        zero;
    logic [31:0] rs_value;
    logic        misalign_err;
    logic [31:0] retired_count;

    modport master (
        output imem_req, imem_addr, instr_valid, opcode, funct, rs, rt, rd, imm,
               pc, link_addr, misalign_err, retired_count,
        input  imem_ready, imem_valid, imem_rdata, decode_ready,
               branch, jump, jal, jr, zero, rs_value
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, opcode, funct, rs, rt, rd, imm,
               pc, link_addr, misalign_err, retired_count,
        output imem_ready, imem_valid, imem_rdata, decode_ready,
               branch, jump, jal, jr, zero, rs_value
    );
endinterface

// File: rtl/pc_sequencer.sv
// PC register, single-outstanding instruction fetch and next-PC selection.
// state   | meaning
// RESET   | out of reset, moves to FETCH on the next clock
// FETCH   | imem_req high at pc, waiting for imem_ready
// WAIT    | request accepted, waiting for imem_valid
// ISSUE   | instruction presented, retires on decode_ready
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    pc_sequencer_if.master    bus
);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_ISSUE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [31:0]       retired_q, retired_d;
    logic              misalign_q, misalign_d;

    logic              retire;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] branch_off;
    logic [ADDR_W-1:0] next_pc;

    assign pc_plus4   = pc_q + 32'd4;
    assign branch_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
    assign retire     = (state_q == S_ISSUE) && bus.decode_ready;

    // jr has top priority, then jump/jal, then taken branch.
    always_comb begin
        next_pc = pc_plus4;
        if (bus.jr) begin
            next_pc = {bus.rs_value[31:2], 2'b00};
        end else if (bus.jump || bus.jal) begin
            next_pc = {pc_plus4[31:28], ir_q[25:0], 2'b00};
        end else if (bus.branch && bus.zero) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        retired_d  = retired_q;
        misalign_d = 1'b0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: if (bus.imem_ready) state_d = S_WAIT;
            S_WAIT: begin
                if (bus.imem_valid) begin
                    ir_d    = bus.imem_rdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (retire) begin
                    pc_d       = next_pc;
                    retired_d  = retired_q + 32'd1;
                    misalign_d = bus.jr && (bus.rs_value[1:0] != 2'b00);
                    state_d    = S_FETCH;
                end
            end
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RESET;
            pc_q       <= RESET_PC;
            ir_q       <= 32'h0;
            retired_q  <= 32'h0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            retired_q  <= retired_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.imem_req      = (state_q == S_FETCH);
    assign bus.imem_addr     = pc_q;
    assign bus.instr_valid   = (state_q == S_ISSUE);
    assign bus.opcode        = ir_q[31:26];
    assign bus.funct         = ir_q[5:0];
    assign bus.rs            = ir_q[25:21];
    assign bus.rt            = ir_q[20:16];
    assign bus.rd            = ir_q[15:11];
    assign bus.imm           = ir_q[15:0];
    assign bus.pc            = pc_q;
    assign bus.link_addr     = pc_plus4;
    assign bus.misalign_err  = misalign_q;
    assign bus.retired_count = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized run
// checked against an arithmetic next-PC / retire-count model.
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_sequencer_if bus ();

    pc_sequencer #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_pc   = 32'h0;
    logic [31:0] exp_cnt  = 32'h0;
    logic [31:0] cur_instr = 32'h0;

    function automatic logic [31:0] model_next(input logic [31:0] pc_v, input logic [31:0] instr,
                                               input bit br, input bit z, input bit j, input bit jl,
                                               input bit jrr, input logic [31:0] rsv);
        logic [31:0] seq;
        int          off;
        seq = pc_v + 32'd4;
        if (jrr) return rsv & 32'hFFFF_FFFC;
        if (j || jl) return (seq & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
        off = int'($signed(instr[15:0]));
        if (br && z) return seq + 32'(off * 4);
        return seq;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        bus.branch = 0; bus.jump = 0; bus.jal = 0; bus.jr = 0; bus.zero = 0;
        bus.rs_value = 32'h0;
    endtask

    // Runs one fetch at exp_pc with imem_ready withheld for 'delay' cycles; leaves DUT in ISSUE.
    task automatic fetch(input logic [31:0] instr, input int delay);
        int   b;
        int   gap;
        b = 0;
        while (bus.imem_req !== 1'b1 && b < 20) begin tick(); b++; end
        n_checks++;
        if (bus.imem_req !== 1'b1) begin
            n_fail++; $display("FAIL fetch_req_timeout got=%b want=1", bus.imem_req); return;
        end
        n_checks++;
        if (bus.imem_addr !== exp_pc) begin
            n_fail++; $display("FAIL fetch_addr got=%h want=%h", bus.imem_addr, exp_pc);
        end
        for (int d = 0; d < delay; d++) begin
            bus.imem_ready = 0; bus.imem_valid = 1'($urandom); bus.imem_rdata = $urandom;
            tick();
            n_checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_pc) begin
                n_fail++; $display("FAIL fetch_hold req=%b addr=%h want req=1 addr=%h",
                                   bus.imem_req, bus.imem_addr, exp_pc);
            end
        end
        bus.imem_ready = 1; bus.imem_valid = 1'($urandom); bus.imem_rdata = $urandom;
        tick();
        bus.imem_ready = 0; bus.imem_valid = 0;
        n_checks++;
        if (bus.imem_req !== 1'b0) begin
            n_fail++; $display("FAIL wait_req_drop got=%b want=0", bus.imem_req);
        end
        n_checks++;
        if (bus.misalign_err !== 1'b0) begin
            n_fail++; $display("FAIL misalign_width got=%b want=0", bus.misalign_err);
        end
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
            bus.imem_ready = 1'($urandom); bus.decode_ready = 1'($urandom);
            tick();
            n_checks++;
            if (bus.instr_valid !== 1'b0 || bus.retired_count !== exp_cnt) begin
                n_fail++; $display("FAIL wait_idle valid=%b cnt=%h want valid=0 cnt=%h",
                                   bus.instr_valid, bus.retired_count, exp_cnt);
            end
        end
        bus.imem_valid = 1; bus.imem_rdata = instr; bus.decode_ready = 0;
        tick();
        bus.imem_valid = 0; bus.imem_rdata = $urandom; bus.imem_ready = 0;
        cur_instr = instr;
        n_checks++;
        if (bus.instr_valid !== 1'b1 || bus.opcode !== instr[31:26] || bus.funct !== instr[5:0] ||
            bus.rs !== instr[25:21] || bus.rt !== instr[20:16] || bus.rd !== instr[15:11] ||
            bus.imm !== instr[15:0]) begin
            n_fail++; $display("FAIL issue_fields valid=%b op=%h fn=%h imm=%h want op=%h fn=%h imm=%h",
                               bus.instr_valid, bus.opcode, bus.funct, bus.imm,
                               instr[31:26], instr[5:0], instr[15:0]);
        end
        n_checks++;
        if (bus.pc !== exp_pc || bus.link_addr !== exp_pc + 32'd4) begin
            n_fail++; $display("FAIL issue_pc pc=%h link=%h want pc=%h link=%h",
                               bus.pc, bus.link_addr, exp_pc, exp_pc + 32'd4);
        end
    endtask

    // Stalls 'stall' cycles in ISSUE, then retires with the given control inputs.
    task automatic retire(input int stall, input bit br, input bit z, input bit j, input bit jl,
                          input bit jrr, input logic [31:0] rsv);
        bit exp_mis;
        for (int s = 0; s < stall; s++) begin
            bus.decode_ready = 0;
            bus.branch = 1'($urandom); bus.jump = 1'($urandom); bus.jr = 1'($urandom);
            bus.zero = 1'($urandom); bus.rs_value = $urandom;
            bus.imem_ready = 1'($urandom); bus.imem_valid = 1'($urandom);
            tick();
            n_checks++;
            if (bus.instr_valid !== 1'b1 || bus.opcode !== cur_instr[31:26] ||
                bus.funct !== cur_instr[5:0] || bus.pc !== exp_pc || bus.imem_req !== 1'b0 ||
                bus.retired_count !== exp_cnt) begin
                n_fail++; $display("FAIL stall_hold valid=%b op=%h pc=%h req=%b cnt=%h want pc=%h cnt=%h",
                                   bus.instr_valid, bus.opcode, bus.pc, bus.imem_req,
                                   bus.retired_count, exp_pc, exp_cnt);
            end
        end
        bus.imem_ready = 0; bus.imem_valid = 0;
        bus.branch = br; bus.zero = z; bus.jump = j; bus.jal = jl; bus.jr = jrr; bus.rs_value = rsv;
        bus.decode_ready = 1;
        tick();
        bus.decode_ready = 0;
        clear_ctrl();
        exp_mis = jrr && (rsv[1:0] != 2'b00);
        exp_pc  = model_next(exp_pc, cur_instr, br, z, j, jl, jrr, rsv);
        exp_cnt = exp_cnt + 32'd1;
        n_checks++;
        if (bus.misalign_err !== exp_mis) begin
            n_fail++; $display("FAIL misalign got=%b want=%b", bus.misalign_err, exp_mis);
        end
        n_checks++;
        if (bus.retired_count !== exp_cnt || bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1) begin
            n_fail++; $display("FAIL retire cnt=%h valid=%b req=%b want cnt=%h valid=0 req=1",
                               bus.retired_count, bus.instr_valid, bus.imem_req, exp_cnt);
        end
    endtask

    task automatic do_reset();
        #2 rst_n = 0;
        #1;
        exp_pc = 32'h0; exp_cnt = 32'h0;
        n_checks++;
        if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.pc !== 32'h0 ||
            bus.retired_count !== 32'h0 || bus.misalign_err !== 1'b0 || bus.opcode !== 6'h0 ||
            bus.imm !== 16'h0) begin
            n_fail++; $display("FAIL reset_state req=%b valid=%b pc=%h cnt=%h mis=%b op=%h imm=%h want all zero",
                               bus.imem_req, bus.instr_valid, bus.pc, bus.retired_count,
                               bus.misalign_err, bus.opcode, bus.imm);
        end
        tick();
        bus.imem_valid = 0; bus.imem_ready = 0;
        rst_n = 1;
    endtask

    task automatic test_reset();
        bus.imem_ready = 0; bus.imem_valid = 0; bus.imem_rdata = 32'h0; bus.decode_ready = 0;
        clear_ctrl();
        tick();
        do_reset();
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            fetch(32'h0000_0020 | ($urandom & 32'h03FF_FFC0), 0);
            retire(0, 0, 0, 0, 0, 0, 32'h0);
        end
        n_checks++;
        if (bus.retired_count !== 32'd3 || bus.imem_addr !== 32'h0000_000C) begin
            n_fail++; $display("FAIL seq_count cnt=%0d addr=%h want cnt=3 addr=0000000c",
                               bus.retired_count, bus.imem_addr);
        end
    endtask

    task automatic test_jump();
        fetch($urandom, 1);
        retire(0, 0, 0, 0, 0, 0, 32'h0);
        fetch(32'h0800_0040, 0);
        retire(0, 0, 0, 1, 0, 0, 32'h0);
        n_checks++;
        if (bus.imem_addr !== 32'h0000_0100) begin
            n_fail++; $display("FAIL jump_target got=%h want=00000100", bus.imem_addr);
        end
    endtask

    task automatic test_branch();
        fetch($urandom, 0);
        retire(0, 0, 0, 0, 0, 1, 32'h0000_0020);
        fetch(32'h1000_FFFE, 0);
        retire(0, 1, 1, 0, 0, 0, 32'h0);
        n_checks++;
        if (bus.imem_addr !== 32'h0000_001C) begin
            n_fail++; $display("FAIL branch_taken got=%h want=0000001c", bus.imem_addr);
        end
        fetch(32'h0000_0000, 0);
        retire(0, 0, 0, 0, 0, 0, 32'h0);
        fetch(32'h1000_FFFE, 0);
        retire(0, 1, 0, 0, 0, 0, 32'h0);
        n_checks++;
        if (bus.imem_addr !== 32'h0000_0024) begin
            n_fail++; $display("FAIL branch_not_taken got=%h want=00000024", bus.imem_addr);
        end
    endtask

    task automatic test_jr();
        fetch(32'h0800_1234, 0);
        retire(0, 0, 0, 1, 0, 1, 32'h0000_0203);
        n_checks++;
        if (bus.imem_addr !== 32'h0000_0200 || bus.misalign_err !== 1'b1) begin
            n_fail++; $display("FAIL jr_misaligned addr=%h mis=%b want addr=00000200 mis=1",
                               bus.imem_addr, bus.misalign_err);
        end
        tick();
        n_checks++;
        if (bus.misalign_err !== 1'b0) begin
            n_fail++; $display("FAIL jr_pulse_width got=%b want=0", bus.misalign_err);
        end
        fetch($urandom, 0);
        retire(0, 0, 0, 0, 0, 1, 32'h0000_0200);
        n_checks++;
        if (bus.imem_addr !== 32'h0000_0200 || bus.misalign_err !== 1'b0) begin
            n_fail++; $display("FAIL jr_aligned addr=%h mis=%b want addr=00000200 mis=0",
                               bus.imem_addr, bus.misalign_err);
        end
    endtask

    task automatic test_stall();
        fetch($urandom, 3);
        retire(5, 0, 0, 0, 0, 0, 32'h0);
        n_checks++;
        if (bus.imem_addr !== 32'h0000_0204) begin
            n_fail++; $display("FAIL stall_resume got=%h want=00000204", bus.imem_addr);
        end
    endtask

    task automatic test_wrap();
        fetch($urandom, 0);
        retire(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        fetch(32'h0000_0025, 0);
        retire(0, 0, 0, 0, 0, 0, 32'h0);
        n_checks++;
        if (bus.imem_addr !== 32'h0000_0000) begin
            n_fail++; $display("FAIL pc_wrap got=%h want=00000000", bus.imem_addr);
        end
    endtask

    task automatic test_random();
        bit br, z, j, jl, jrr;
        logic [31:0] rsv;
        for (int i = 0; i < 40; i++) begin
            fetch($urandom, $urandom_range(0, 3));
            br  = ($urandom_range(0, 2) == 0);
            z   = 1'($urandom);
            j   = ($urandom_range(0, 4) == 0);
            jl  = ($urandom_range(0, 5) == 0);
            jrr = ($urandom_range(0, 4) == 0);
            rsv = $urandom;
            retire($urandom_range(0, 3), br, z, j, jl, jrr, rsv);
        end
    endtask

    task automatic test_reset_mid();
        int b;
        fetch($urandom, 0);
        retire(0, 0, 0, 0, 0, 1, 32'h0000_4440);
        b = 0;
        while (bus.imem_req !== 1'b1 && b < 20) begin tick(); b++; end
        bus.imem_ready = 1;
        tick();
        bus.imem_ready = 0;
        bus.imem_valid = 1; bus.imem_rdata = $urandom;
        do_reset();
        fetch(32'h2108_5555, 0);
        do_reset();
        fetch(32'h0000_0008, 0);
        retire(0, 0, 0, 0, 0, 0, 32'h0);
        n_checks++;
        if (bus.retired_count !== 32'd1 || bus.imem_addr !== 32'h0000_0004) begin
            n_fail++; $display("FAIL post_reset cnt=%0d addr=%h want cnt=1 addr=00000004",
                               bus.retired_count, bus.imem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jump();
        test_branch();
        test_jr();
        test_stall();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
